// File: rtl/parc_mem_req_responder.sv
// parc_mem_req_responder
// Memory-side responder for the PARCv2 val/rdy memory interface. Requests are
// serviced from an internal word array in the cycle they are accepted. Responses
// travel through a fixed-latency pipeline into an in-order response FIFO. The
// number of outstanding requests is capped at QDEPTH, so the FIFO never overflows.

module parc_mem_req_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_msg_type,
    input  logic [31:0] memreq_msg_addr,
    input  logic [1:0]  memreq_msg_len,
    input  logic [31:0] memreq_msg_data,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_msg_type,
    output logic [1:0]  memresp_msg_len,
    output logic [31:0] memresp_msg_data,
    input  logic        init_en,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(QDEPTH);

    typedef struct packed {
        logic        typ;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_t;

    logic [31:0]          r_mem [DEPTH];
    resp_t                r_fifo [QDEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_outst;

    logic [ADDR_BITS-1:0] w_req_idx;
    logic [ADDR_BITS-1:0] w_init_idx;
    logic [1:0]           w_off;
    logic [2:0]           w_nbytes;
    logic [3:0]           w_byte_hit;
    logic [31:0]          w_hit_mask;
    logic [31:0]          w_rd_word;
    logic [31:0]          w_rd_data;
    logic [31:0]          w_wr_data;
    logic                 w_req_fire;
    logic                 w_resp_fire;
    logic                 w_wr_fire;
    logic                 w_wr_blocked;
    logic                 w_push;
    resp_t                w_new_resp;
    resp_t                w_push_resp;
    logic                 w_unused;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes depend only on registered state, forced low while in reset.
    assign memreq_rdy  = ~reset & (r_outst < MAX_CNT);
    assign memresp_val = ~reset & (r_count != '0);
    assign w_req_fire  = memreq_val & memreq_rdy;
    assign w_resp_fire = memresp_val & memresp_rdy;
    assign w_wr_fire   = w_req_fire & memreq_msg_type;

    // Upper address bits alias the array; init ignores the byte offset.
    assign w_req_idx    = memreq_msg_addr[ADDR_BITS+1:2];
    assign w_init_idx   = init_addr[ADDR_BITS+1:2];
    assign w_off        = memreq_msg_addr[1:0];
    assign w_nbytes     = (memreq_msg_len == 2'd0) ? 3'd4 : {1'b0, memreq_msg_len};
    assign w_wr_blocked = init_en & (w_init_idx == w_req_idx);
    assign w_unused     = ^{memreq_msg_addr[31:ADDR_BITS+2], init_addr[31:ADDR_BITS+2], init_addr[1:0]};

    // Byte lanes touched by the request; lanes past the word boundary are dropped.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        w_byte_hit = '0;
        for (int b = 0; b < 4; b++) begin
            if (b >= int'(w_off) && (b - int'(w_off)) < int'(w_nbytes)) begin
                w_byte_hit[b] = 1'b1;
            end
        end
    end

    assign w_hit_mask = {{8{w_byte_hit[3]}}, {8{w_byte_hit[2]}}, {8{w_byte_hit[1]}}, {8{w_byte_hit[0]}}};
    assign w_rd_word  = r_mem[w_req_idx];
    assign w_rd_data  = (w_rd_word & w_hit_mask) >> {w_off, 3'b000};
    assign w_wr_data  = memreq_msg_data << {w_off, 3'b000};

    // Response formed in the acceptance cycle from pre-write array contents.
    always_comb begin
        w_new_resp      = '0;
        w_new_resp.typ  = memreq_msg_type;
        w_new_resp.len  = memreq_msg_len;
        w_new_resp.data = memreq_msg_type ? 32'h0 : w_rd_data;
    end

    // Array writes: request byte lanes, then backdoor word; backdoor wins a same-word collision.
    always_ff @(posedge clk) begin
        // NOTE: the array is intentionally not reset; contents survive reset.
        if (w_wr_fire && !w_wr_blocked) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_hit[b]) begin
                    r_mem[w_req_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
        if (init_en) begin
            r_mem[w_init_idx] <= init_data;
        end
    end

    // Fixed-latency delay line; LATENCY-1 stages ahead of the FIFO push.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign w_push      = w_req_fire;
            assign w_push_resp = w_new_resp;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_pv;
            resp_t              r_pd [LATENCY-1];

            // Shift accepted responses toward the FIFO one stage per cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_req_fire;
                    r_pd[0] <= w_new_resp;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        r_pv[s] <= r_pv[s-1];
                        r_pd[s] <= r_pd[s-1];
                    end
                end
            end

            assign w_push      = r_pv[LATENCY-2];
            assign w_push_resp = r_pd[LATENCY-2];
        end
    endgenerate

    // FIFO storage; visibility is governed by r_count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_resp;
        end
    end

    // FIFO pointers, occupancy and outstanding-request count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_outst  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_resp_fire) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_resp_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_outst <= r_outst + CNT_W'(1);
                2'b01:   r_outst <= r_outst - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Head of FIFO drives the response message; held until it is consumed.
    assign memresp_msg_type = r_fifo[r_rd_ptr].typ;
    assign memresp_msg_len  = r_fifo[r_rd_ptr].len;
    assign memresp_msg_data = r_fifo[r_rd_ptr].data;

endmodule

// File: tb/tb_parc_mem_req_responder.sv
// Self-checking bench for parc_mem_req_responder: a transaction-level model
// (word array plus ordered list of expected responses with due cycles) checked
// every cycle, plus directed scenarios with hand-computed literal results.

module tb_parc_mem_req_responder;

    localparam int AB  = 10;
    localparam int LAT = 2;
    localparam int QD  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_msg_type;
    logic [31:0] memreq_msg_addr;
    logic [1:0]  memreq_msg_len;
    logic [31:0] memreq_msg_data;
    logic        memresp_val;
    logic        memresp_rdy;
    logic        memresp_msg_type;
    logic [1:0]  memresp_msg_len;
    logic [31:0] memresp_msg_data;
    logic        init_en;
    logic [31:0] init_addr;
    logic [31:0] init_data;

    parc_mem_req_responder #(.ADDR_BITS(AB), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clk              (clk),
        .reset            (reset),
        .memreq_val       (memreq_val),
        .memreq_rdy       (memreq_rdy),
        .memreq_msg_type  (memreq_msg_type),
        .memreq_msg_addr  (memreq_msg_addr),
        .memreq_msg_len   (memreq_msg_len),
        .memreq_msg_data  (memreq_msg_data),
        .memresp_val      (memresp_val),
        .memresp_rdy      (memresp_rdy),
        .memresp_msg_type (memresp_msg_type),
        .memresp_msg_len  (memresp_msg_len),
        .memresp_msg_data (memresp_msg_data),
        .init_en          (init_en),
        .init_addr        (init_addr),
        .init_data        (init_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic        typ;
        logic [1:0]  len;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        typ;
        logic [1:0]  len;
        logic [31:0] data;
        int          c;
    } got_t;

    logic [31:0] mdl_mem [1 << AB];
    exp_t        exp_q[$];
    got_t        got_q[$];

    function automatic logic [31:0] mdl_read(input logic [31:0] a, input logic [1:0] l);
        int          o = int'(a[1:0]);
        int          n = (l == 2'd0) ? 4 : int'(l);
        logic [31:0] w = mdl_mem[a[AB+1:2]];
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) begin
            if (o + k < 4) r[8*k +: 8] = w[8*(o+k) +: 8];
        end
        return r;
    endfunction

    function automatic void mdl_write(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        int o = int'(a[1:0]);
        int n = (l == 2'd0) ? 4 : int'(l);
        for (int k = 0; k < n; k++) begin
            if (o + k < 4) mdl_mem[a[AB+1:2]][8*(o+k) +: 8] = d[8*k +: 8];
        end
    endfunction

    logic        exp_val;
    logic        prev_hold = 1'b0;
    logic        prev_typ;
    logic [1:0]  prev_len;
    logic [31:0] prev_data;
    exp_t        new_exp;
    got_t        new_got;

    // Compare process: every cycle, on the falling edge, against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("reset_req_rdy", {31'b0, memreq_rdy}, 32'd0);
            check("reset_resp_val", {31'b0, memresp_val}, 32'd0);
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            exp_val = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            check("resp_val", {31'b0, memresp_val}, {31'b0, exp_val});
            check("req_rdy", {31'b0, memreq_rdy}, {31'b0, (exp_q.size() < QD)});
            if (exp_val) begin
                check("resp_type", {31'b0, memresp_msg_type}, {31'b0, exp_q[0].typ});
                check("resp_len", {30'b0, memresp_msg_len}, {30'b0, exp_q[0].len});
                check("resp_data", memresp_msg_data, exp_q[0].data);
            end
            if (prev_hold) begin
                check("hold_type", {31'b0, memresp_msg_type}, {31'b0, prev_typ});
                check("hold_len", {30'b0, memresp_msg_len}, {30'b0, prev_len});
                check("hold_data", memresp_msg_data, prev_data);
            end
            prev_hold = memresp_val & ~memresp_rdy;
            prev_typ  = memresp_msg_type;
            prev_len  = memresp_msg_len;
            prev_data = memresp_msg_data;
            if (memresp_val && memresp_rdy) begin
                new_got.typ  = memresp_msg_type;
                new_got.len  = memresp_msg_len;
                new_got.data = memresp_msg_data;
                new_got.c    = cyc;
                got_q.push_back(new_got);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (memreq_val && memreq_rdy) begin
                new_exp.typ  = memreq_msg_type;
                new_exp.len  = memreq_msg_len;
                new_exp.data = memreq_msg_type ? 32'h0 : mdl_read(memreq_msg_addr, memreq_msg_len);
                new_exp.due  = cyc + LAT;
                exp_q.push_back(new_exp);
                if (memreq_msg_type) mdl_write(memreq_msg_addr, memreq_msg_len, memreq_msg_data);
            end
        end
        if (init_en) mdl_mem[init_addr[AB+1:2]] = init_data;
    end

    // ---------------- stimulus helpers ----------------
    task automatic init_word(input logic [31:0] a, input logic [31:0] d);
        init_en   = 1'b1;
        init_addr = a;
        init_data = d;
        @(posedge clk); #1;
        init_en   = 1'b0;
    endtask

    // Present a request and hold it until accepted; leaves memreq_val high.
    task automatic send_req(input logic t, input logic [31:0] a, input logic [1:0] l,
                            input logic [31:0] d, output int acc_cyc);
        memreq_val      = 1'b1;
        memreq_msg_type = t;
        memreq_msg_addr = a;
        memreq_msg_len  = l;
        memreq_msg_data = d;
        acc_cyc = -1;
        for (int i = 0; i < 50 && acc_cyc < 0; i++) begin
            @(negedge clk);
            if (memreq_rdy) acc_cyc = cyc;
            @(posedge clk); #1;
        end
        check("req_accepted", {31'b0, (acc_cyc >= 0)}, 32'd1);
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 40 && got_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        check("resp_count", got_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        int acc;
        reset = 1'b1;
        memreq_val = 1'b0; memreq_msg_type = 1'b0; memreq_msg_addr = '0;
        memreq_msg_len = '0; memreq_msg_data = '0;
        memresp_rdy = 1'b1;
        init_en = 1'b0; init_addr = '0; init_data = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rdy_first_cycle_after_reset", {31'b0, memreq_rdy}, 32'd1);
        check("val_first_cycle_after_reset", {31'b0, memresp_val}, 32'd0);
        @(posedge clk); #1;

        init_word(32'h100, 32'hdeadbeef);
        init_word(32'h000, 32'h12345678);
        for (int i = 0; i < 6; i++) init_word(32'h200 + 32'(4*i), 32'h11111111 * 32'(i + 1));

        // Aligned read: latency and echo fields.
        b = got_q.size();
        send_req(1'b0, 32'h100, 2'd0, 32'h0, a);
        memreq_val = 1'b0;
        wait_got(b + 1);
        check("lw_data", got_q[b].data, 32'hdeadbeef);
        check("lw_type", {31'b0, got_q[b].typ}, 32'd0);
        check("lw_len", {30'b0, got_q[b].len}, 32'd0);
        check("lw_latency", 32'(got_q[b].c - a), 32'd2);

        // Sub-word reads, back to back, including a boundary-crossing half.
        b = got_q.size();
        send_req(1'b0, 32'h103, 2'd1, 32'h0, a);
        send_req(1'b0, 32'h102, 2'd2, 32'h0, a);
        send_req(1'b0, 32'h103, 2'd2, 32'h0, a);
        memreq_val = 1'b0;
        wait_got(b + 3);
        check("lb_103", got_q[b].data, 32'h000000de);
        check("lhu_102", got_q[b+1].data, 32'h0000dead);
        check("lh_103_cross", got_q[b+2].data, 32'h000000de);
        check("lb_len_echo", {30'b0, got_q[b].len}, 32'd1);

        // Address wrap: 0x1000 aliases word 0.
        b = got_q.size();
        send_req(1'b0, 32'h1000, 2'd0, 32'h0, a);
        memreq_val = 1'b0;
        wait_got(b + 1);
        check("wrap_read", got_q[b].data, 32'h12345678);

        // Backpressure: 6 reads offered with memresp_rdy low.
        b = got_q.size();
        memresp_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            memreq_val = 1'b1; memreq_msg_type = 1'b0; memreq_msg_len = 2'd0;
            memreq_msg_addr = 32'h200 + 32'(4*acc);
            @(negedge clk);
            if (memreq_rdy) acc++;
            @(posedge clk); #1;
        end
        check("bp_accepted", acc, 32'd4);
        check("bp_req_rdy_low", {31'b0, memreq_rdy}, 32'd0);
        check("bp_head_val", {31'b0, memresp_val}, 32'd1);
        check("bp_head_data", memresp_msg_data, 32'h11111111);
        memresp_rdy = 1'b1;
        for (int i = 0; i < 20 && acc < 6; i++) begin
            memreq_val = 1'b1;
            memreq_msg_addr = 32'h200 + 32'(4*acc);
            @(negedge clk);
            if (memreq_rdy) acc++;
            @(posedge clk); #1;
        end
        memreq_val = 1'b0;
        check("bp_all_accepted", acc, 32'd6);
        wait_got(b + 6);
        for (int k = 0; k < 6; k++) check("bp_order", got_q[b+k].data, 32'h11111111 * 32'(k + 1));
        for (int k = 1; k < 4; k++) check("bp_back_to_back", 32'(got_q[b+k].c - got_q[b].c), 32'(k));

        // Reset with 3 reads outstanding: nothing is presented afterwards, array kept.
        b = got_q.size();
        memresp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) send_req(1'b0, 32'h100, 2'd0, 32'h0, a);
        memreq_val = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        memresp_rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("no_resp_after_reset", got_q.size(), b);
        send_req(1'b0, 32'h100, 2'd0, 32'h0, a);
        memreq_val = 1'b0;
        wait_got(b + 1);
        check("array_kept_after_reset", got_q[b].data, 32'hdeadbeef);

        // Byte write then word read, back to back.
        b = got_q.size();
        send_req(1'b1, 32'h101, 2'd1, 32'hffffff55, a);
        send_req(1'b0, 32'h100, 2'd0, 32'h0, a);
        memreq_val = 1'b0;
        wait_got(b + 2);
        check("sb_type", {31'b0, got_q[b].typ}, 32'd1);
        check("sb_data", got_q[b].data, 32'h0);
        check("sb_len", {30'b0, got_q[b].len}, 32'd1);
        check("lw_after_sb_type", {31'b0, got_q[b+1].typ}, 32'd0);
        check("lw_after_sb", got_q[b+1].data, 32'hdead55ef);

        // Half write across the word boundary: upper byte dropped.
        b = got_q.size();
        send_req(1'b1, 32'h103, 2'd2, 32'h00001177, a);
        send_req(1'b0, 32'h100, 2'd0, 32'h0, a);
        memreq_val = 1'b0;
        wait_got(b + 2);
        check("sh_cross_read", got_q[b+1].data, 32'h77ad55ef);

        // Backdoor write beats a same-cycle request write to the same word.
        b = got_q.size();
        init_en = 1'b1; init_addr = 32'h300; init_data = 32'hcafef00d;
        send_req(1'b1, 32'h300, 2'd0, 32'h0badbeef, a);
        init_en = 1'b0;
        send_req(1'b0, 32'h300, 2'd0, 32'h0, a);
        memreq_val = 1'b0;
        wait_got(b + 2);
        check("init_priority", got_q[b+1].data, 32'hcafef00d);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
